// File: rtl/pu_master_spi.sv
// pu_master_spi: NITTA PU acting as SPI master (mode 0) with ping-pong tx/rx word banks.
// Define PU_MASTER_SPI_LOOPBACK_EN to sample miso internally from mosi (miso port ignored).
module pu_master_spi #(
   parameter int DATA_WIDTH     = 32,
   parameter int ATTR_WIDTH     = 4,
   parameter int SPI_DATA_WIDTH = 8,
   parameter int BUF_SIZE       = 6,
   parameter int SCLK_HALF      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signal_cycle,
   input  logic                  signal_wr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ATTR_WIDTH-1:0] attr_in,
   input  logic                  signal_oe,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ATTR_WIDTH-1:0] attr_out,
   output logic                  flag_stop,
   output logic                  cs,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso
);
   localparam int FRAMES = DATA_WIDTH / SPI_DATA_WIDTH;
   localparam int PW = $clog2(BUF_SIZE + 1);
   localparam int BW = $clog2(SPI_DATA_WIDTH + 1);
   localparam int FW = $clog2(FRAMES + 1);
   localparam int TW = $clog2(SCLK_HALF + 1);
   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
   state_t r_state, w_next;
   logic [DATA_WIDTH-1:0] r_tx [2][BUF_SIZE];
   logic [DATA_WIDTH-1:0] r_rx [2][BUF_SIZE];
   logic [DATA_WIDTH-1:0] r_txsr, r_rxsr;
   logic [PW-1:0] r_wr_cnt, r_n, r_rd_n, r_rd_ptr, r_word;
   logic [BW-1:0] r_bit;
   logic [FW-1:0] r_frm;
   logic [TW-1:0] r_tmr;
   logic r_sel, r_ovr, r_cs, r_sclk, r_flag;
   logic w_swap, w_wrap, w_rise, w_fall, w_frame_end, w_word_done, w_miso, w_unused;
`ifdef PU_MASTER_SPI_LOOPBACK_EN
   assign w_miso   = mosi;
   assign w_unused = ^{attr_in, miso};
`else
   assign w_miso   = miso;
   assign w_unused = ^attr_in;
`endif
   assign w_swap      = signal_cycle && r_state == IDLE;
   assign w_wrap      = r_tmr == TW'(SCLK_HALF - 1);
   assign w_rise      = w_wrap && (r_state == SETUP || (r_state == SHIFT && !r_sclk && r_word != r_n));
   assign w_fall      = w_wrap && r_state == SHIFT && r_sclk;
   assign w_frame_end = r_bit == BW'(SPI_DATA_WIDTH - 1);
   assign w_word_done = w_frame_end && r_frm == FW'(FRAMES - 1);
   assign cs        = r_cs;
   assign sclk      = r_sclk;
   assign mosi      = !r_cs && r_txsr[DATA_WIDTH-1];
   assign flag_stop = r_flag;
   assign attr_out  = ATTR_WIDTH'(r_ovr);
   assign data_out  = (signal_oe && r_rd_ptr < r_rd_n) ? r_rx[~r_sel][r_rd_ptr] : '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_comb begin
      w_next = r_state;
      if (w_swap && r_wr_cnt != '0) w_next = SETUP;
      if (r_state == SETUP && w_wrap) w_next = SHIFT;
      if (r_state == SHIFT && w_wrap && !r_sclk && r_word == r_n) w_next = HOLD;
      if (r_state == HOLD && w_wrap) w_next = IDLE;
   end
   // Bank storage has no reset: counters alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (signal_wr && (w_swap || r_wr_cnt != PW'(BUF_SIZE)))
         r_tx[w_swap ? ~r_sel : r_sel][w_swap ? '0 : r_wr_cnt] <= data_in;
      if (w_rise && w_word_done)
         r_rx[r_sel][r_word] <= {r_rxsr[DATA_WIDTH-2:0], w_miso};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel    <= 1'b0;
         r_ovr    <= 1'b0;
         r_cs     <= 1'b1;
         r_sclk   <= 1'b0;
         r_flag   <= 1'b0;
         r_tmr    <= '0;
         r_wr_cnt <= '0;
         r_n      <= '0;
         r_rd_n   <= '0;
         r_rd_ptr <= '0;
         r_word   <= '0;
         r_bit    <= '0;
         r_frm    <= '0;
         r_txsr   <= '0;
         r_rxsr   <= '0;
      end else begin
         r_flag   <= r_state == HOLD && w_wrap;
         r_tmr    <= (r_state == IDLE || w_wrap) ? '0 : r_tmr + TW'(1);
         r_wr_cnt <= w_swap ? PW'(signal_wr) : r_wr_cnt + PW'(signal_wr && r_wr_cnt != PW'(BUF_SIZE));
         r_rd_ptr <= w_swap ? '0 : r_rd_ptr + PW'(signal_oe && r_rd_ptr < r_rd_n);
         if (signal_cycle && r_state != IDLE) r_ovr <= 1'b1;
         if (w_swap) begin
            r_sel  <= ~r_sel;
            r_n    <= r_wr_cnt;
            r_rd_n <= r_n;
            r_word <= '0;
            r_bit  <= '0;
            r_frm  <= '0;
            r_txsr <= r_tx[r_sel][0];
            r_cs   <= r_wr_cnt == '0;
         end
         if (w_rise) begin
            r_sclk <= 1'b1;
            r_rxsr <= {r_rxsr[DATA_WIDTH-2:0], w_miso};
            r_bit  <= w_frame_end ? '0 : r_bit + BW'(1);
            r_frm  <= w_frame_end ? (w_word_done ? '0 : r_frm + FW'(1)) : r_frm;
            r_word <= r_word + PW'(w_word_done);
         end
         // Word boundary reached when the bit/frame counters have just wrapped.
         if (w_fall) begin
            r_sclk <= 1'b0;
            r_txsr <= (r_bit == '0 && r_frm == '0) ? (r_word != r_n ? r_tx[~r_sel][r_word] : r_txsr)
                                                  : r_txsr << 1;
         end
         if (r_state == HOLD && w_wrap) r_cs <= 1'b1;
      end
   end
endmodule
